ddr_crc5_engine: RTL and testbench

Byte-serial CRC-5 engine for the HDR-DDR receive path. It sits directly downstream of the RX deserializer and consumes each received data byte that RX flags with its CRC data-valid strobe. It accumulates the HDR-DDR CRC-5 (x^5 + x^2 + 1) over all bytes of a transfer and returns the running checksum to RX for comparison against the CRC word received after the CRC token. The engine processes one bit per system clock, MSB first.

---
 rtl/ddr_crc5_engine_if.sv | 33 +++
 rtl/ddr_crc5_engine.sv | 101 ++++++++++
 tb/tb_ddr_crc5_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ddr_crc5_engine_if.sv
// RX-to-CRC handshake bundle: byte strobe and enable from RX, checksum and status back.
// RX drives the master side; the CRC engine sits on the slave side.
interface ddr_crc5_engine_if #(
  parameter int unsigned DataWidth = 8
);
  logic                 i_rx_crc_en;
  logic                 i_rx_crc_data_valid;
  logic [DataWidth-1:0] i_rx_crc_data;
  logic [4:0]           o_crc_value;
  logic                 o_crc_valid;
  logic                 o_crc_busy;
  logic                 o_crc_overrun;

  modport master (
    output i_rx_crc_en,
    output i_rx_crc_data_valid,
    output i_rx_crc_data,
    input  o_crc_value,
    input  o_crc_valid,
    input  o_crc_busy,
    input  o_crc_overrun
  );

  modport slave (
    input  i_rx_crc_en,
    input  i_rx_crc_data_valid,
    input  i_rx_crc_data,
    output o_crc_value,
    output o_crc_valid,
    output o_crc_busy,
    output o_crc_overrun
  );
endinterface

// File: rtl/ddr_crc5_engine.sv
// Byte-serial HDR-DDR CRC-5 (x^5 + x^2 + 1), one bit per clock, MSB first.
// Accumulates across all bytes of a transfer; cleared whenever the RX enable window is low.
module ddr_crc5_engine #(
  parameter int unsigned DataWidth = 8,
  parameter logic [4:0]  CrcInit   = 5'b11111,
  parameter logic [4:0]  CrcPoly   = 5'b00101
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  ddr_crc5_engine_if.slave   bus
);

  localparam int unsigned CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e               state_q, state_d;
  logic [4:0]           lfsr_q, lfsr_d;
  logic [DataWidth-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
  logic                 fb;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    fb        = lfsr_q[4] ^ sreg_q[DataWidth-1];

    // Enable low clears exactly like reset and overrides any strobe or in-flight byte.
    if (!bus.i_rx_crc_en) begin
      state_d   = StIdle;
      lfsr_d    = CrcInit;
      sreg_d    = '0;
      cnt_d     = '0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_rx_crc_data_valid) begin
            sreg_d  = bus.i_rx_crc_data;
            cnt_d   = '0;
            state_d = StShift;
            busy_d  = 1'b1;
            valid_d = 1'b0;
          end
        end
        StShift: begin
          // Galois step: shift left, XOR taps in when the outgoing bit differs from data.
          lfsr_d = {lfsr_q[3:0], 1'b0} ^ (fb ? CrcPoly : 5'b00000);
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            valid_d = 1'b1;
          end
          if (bus.i_rx_crc_data_valid) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state_q   <= StIdle;
      lfsr_q    <= CrcInit;
      sreg_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_crc_value   = lfsr_q;
  assign bus.o_crc_valid   = valid_q;
  assign bus.o_crc_busy    = busy_q;
  assign bus.o_crc_overrun = overrun_q;

endmodule

// File: tb/tb_ddr_crc5_engine.sv
// Directed bench for ddr_crc5_engine: inputs change and outputs are sampled on falling edges.
module tb_ddr_crc5_engine;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ddr_crc5_engine_if #(.DataWidth(8)) bus ();

  ddr_crc5_engine #(
    .DataWidth(8),
    .CrcInit  (5'b11111),
    .CrcPoly  (5'b00101)
  ) dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a byte for exactly one rising edge; returns at the falling edge after it.
  task automatic send_byte(input logic [7:0] data);
    bus.i_rx_crc_data_valid = 1'b1;
    bus.i_rx_crc_data       = data;
    @(negedge clk);
    bus.i_rx_crc_data_valid = 1'b0;
  endtask

  task automatic restart();
    bus.i_rx_crc_en = 1'b0;
    step(1);
    bus.i_rx_crc_en = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n                   = 1'b0;
    bus.i_rx_crc_en         = 1'b1;
    bus.i_rx_crc_data_valid = 1'b1;
    bus.i_rx_crc_data       = 8'h5A;

    // Reset with enable high and strobes toggling.
    @(negedge clk);
    bus.i_rx_crc_data_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_value", 32'(bus.o_crc_value), 32'h1F);
    check_eq("rst_valid", 32'(bus.o_crc_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.o_crc_busy), 32'd0);
    check_eq("rst_overrun", 32'(bus.o_crc_overrun), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Single byte: busy after E0..E7, valid after E8.
    send_byte(8'hA1);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("single_busy_%0d", i), 32'(bus.o_crc_busy), 32'd1);
      check_eq($sformatf("single_nvalid_%0d", i), 32'(bus.o_crc_valid), 32'd0);
      step(1);
    end
    check_eq("single_busy_done", 32'(bus.o_crc_busy), 32'd0);
    check_eq("single_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("single_value", 32'(bus.o_crc_value), 32'h15);
    step(5);
    check_eq("single_hold_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("single_hold_value", 32'(bus.o_crc_value), 32'h15);

    // Enable drop clears; strobe on the same edge enable rises is accepted.
    bus.i_rx_crc_en = 1'b0;
    step(1);
    check_eq("dis_value", 32'(bus.o_crc_value), 32'h1F);
    check_eq("dis_valid", 32'(bus.o_crc_valid), 32'd0);
    bus.i_rx_crc_en = 1'b1;
    send_byte(8'hA1);
    check_eq("two_first_busy", 32'(bus.o_crc_busy), 32'd1);
    step(8);
    check_eq("two_first_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("two_first_value", 32'(bus.o_crc_value), 32'h15);
    step(7);
    send_byte(8'hD4);
    check_eq("two_second_nvalid", 32'(bus.o_crc_valid), 32'd0);
    step(4);
    check_eq("two_mid_nvalid", 32'(bus.o_crc_valid), 32'd0);
    check_eq("two_mid_busy", 32'(bus.o_crc_busy), 32'd1);
    step(4);
    check_eq("two_final_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("two_final_value", 32'(bus.o_crc_value), 32'h15);
    check_eq("two_no_overrun", 32'(bus.o_crc_overrun), 32'd0);

    // Fresh transfer over 0x00 from the init value.
    restart();
    send_byte(8'h00);
    step(8);
    check_eq("zero_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("zero_value", 32'(bus.o_crc_value), 32'h0F);

    // Overrun: second strobe at E3 is dropped.
    restart();
    send_byte(8'hA1);
    step(2);
    send_byte(8'hFF);
    check_eq("ovr_flag", 32'(bus.o_crc_overrun), 32'd1);
    step(5);
    check_eq("ovr_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("ovr_value", 32'(bus.o_crc_value), 32'h15);
    step(6);
    check_eq("ovr_sticky", 32'(bus.o_crc_overrun), 32'd1);
    check_eq("ovr_idle_busy", 32'(bus.o_crc_busy), 32'd0);
    bus.i_rx_crc_en = 1'b0;
    step(1);
    check_eq("ovr_cleared", 32'(bus.o_crc_overrun), 32'd0);
    bus.i_rx_crc_en = 1'b1;

    // Boundary: strobes at E0, E8 (dropped) and E9 (accepted).
    step(1);
    send_byte(8'h00);
    step(7);
    send_byte(8'hFF);
    check_eq("bnd_e8_overrun", 32'(bus.o_crc_overrun), 32'd1);
    check_eq("bnd_e8_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("bnd_e8_busy", 32'(bus.o_crc_busy), 32'd0);
    check_eq("bnd_e8_value", 32'(bus.o_crc_value), 32'h0F);
    send_byte(8'hA1);
    check_eq("bnd_e9_busy", 32'(bus.o_crc_busy), 32'd1);
    check_eq("bnd_e9_nvalid", 32'(bus.o_crc_valid), 32'd0);
    step(8);
    check_eq("bnd_e17_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("bnd_e17_busy", 32'(bus.o_crc_busy), 32'd0);

    // Abort mid-byte at E4, then a clean transfer.
    restart();
    send_byte(8'hA1);
    step(3);
    bus.i_rx_crc_en = 1'b0;
    step(1);
    check_eq("abort_busy", 32'(bus.o_crc_busy), 32'd0);
    check_eq("abort_valid", 32'(bus.o_crc_valid), 32'd0);
    check_eq("abort_value", 32'(bus.o_crc_value), 32'h1F);
    step(2);
    check_eq("abort_idle_busy", 32'(bus.o_crc_busy), 32'd0);
    bus.i_rx_crc_en = 1'b1;
    step(1);
    send_byte(8'hA1);
    step(8);
    check_eq("reen_valid", 32'(bus.o_crc_valid), 32'd1);
    check_eq("reen_value", 32'(bus.o_crc_value), 32'h15);
    check_eq("reen_overrun", 32'(bus.o_crc_overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
